// File: rtl/data_memory_arbiter_if.sv
// Shared types and the bundled bus between MEM stage, DMA loader and
// the single-port data memory, as seen by the data memory arbiter.
package data_memory_arbiter_pkg;

    typedef enum logic [2:0] {
        ORIGIN_BYTE  = 3'd0,
        ORIGIN_HALF  = 3'd1,
        ORIGIN_WORD  = 3'd2,
        ORIGIN_UBYTE = 3'd3,
        ORIGIN_UHALF = 3'd4
    } read_type_t;

    typedef enum logic [1:0] {
        WRITE_NONE = 2'd0,
        WRITE_BYTE = 2'd1,
        WRITE_HALF = 2'd2,
        WRITE_WORD = 2'd3
    } write_type_t;

endpackage

interface data_memory_arbiter_if;
    import data_memory_arbiter_pkg::*;

    logic        cpuReq;
    logic [31:0] cpuAddress;
    read_type_t  cpuReadType;
    logic        cpuWriteEnable;
    logic [31:0] cpuWriteValue;
    write_type_t cpuWriteType;
    logic        cpuStall;
    logic [31:0] cpuReadResult;

    logic        dmaReq;
    logic [31:0] dmaAddress;
    logic        dmaWriteEnable;
    logic [31:0] dmaWriteValue;
    logic        dmaGrant;
    logic        dmaReadValid;
    logic [31:0] dmaReadData;

    logic [31:0] memAddress;
    read_type_t  memReadType;
    logic        memWriteEnable;
    logic [31:0] memWriteValue;
    write_type_t memWriteType;
    logic [31:0] memReadResult;

    // Arbiter side: consumes requests, drives the memory.
    modport slave (
        input  cpuReq, cpuAddress, cpuReadType,
        input  cpuWriteEnable, cpuWriteValue, cpuWriteType,
        input  dmaReq, dmaAddress, dmaWriteEnable, dmaWriteValue,
        input  memReadResult,
        output cpuStall, cpuReadResult,
        output dmaGrant, dmaReadValid, dmaReadData,
        output memAddress, memReadType, memWriteEnable,
        output memWriteValue, memWriteType
    );

    // Requester/memory side: the environment around the arbiter.
    modport master (
        output cpuReq, cpuAddress, cpuReadType,
        output cpuWriteEnable, cpuWriteValue, cpuWriteType,
        output dmaReq, dmaAddress, dmaWriteEnable, dmaWriteValue,
        output memReadResult,
        input  cpuStall, cpuReadResult,
        input  dmaGrant, dmaReadValid, dmaReadData,
        input  memAddress, memReadType, memWriteEnable,
        input  memWriteValue, memWriteType
    );

endinterface

// File: rtl/data_memory_arbiter.sv
// Data memory arbiter: CPU has fixed priority, a starvation counter
// forces a one-cycle DMA grant (stalling the CPU) after STARVE_LIMIT waits.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int WAIT_WIDTH   = 8
) (
    input logic                   clock,
    input logic                   reset,
    data_memory_arbiter_if.slave  bus
);

    localparam logic [WAIT_WIDTH-1:0] LIMIT =
        WAIT_WIDTH'(STARVE_LIMIT);

    logic [WAIT_WIDTH-1:0] wait_count_q;
    logic [WAIT_WIDTH-1:0] wait_count_d;
    logic                  dma_read_valid_q;
    logic                  dma_read_valid_d;
    logic [31:0]           dma_read_data_q;
    logic [31:0]           dma_read_data_d;
    logic                  force_dma;
    logic                  dma_grant;

    // Grant decision: DMA wins when CPU is idle or DMA has starved.
    always_comb begin
        force_dma = bus.dmaReq && (wait_count_q == LIMIT);
        dma_grant = !reset && bus.dmaReq
                    && (!bus.cpuReq || force_dma);
        bus.dmaGrant      = dma_grant;
        bus.cpuStall      = !reset && bus.cpuReq && dma_grant;
        bus.cpuReadResult = bus.memReadResult;
    end

    // Starvation counter: cleared on grant or idle DMA, else saturates.
    always_comb begin
        wait_count_d = wait_count_q;
        if (reset || dma_grant || !bus.dmaReq) begin
            wait_count_d = '0;
        end else if (wait_count_q < LIMIT) begin
            wait_count_d = wait_count_q + WAIT_WIDTH'(1);
        end else begin
            wait_count_d = LIMIT;
        end
    end

    // Memory request mux: a granted DMA access is always a word access.
    always_comb begin
        bus.memAddress     = bus.cpuAddress;
        bus.memReadType    = bus.cpuReadType;
        bus.memWriteValue  = bus.cpuWriteValue;
        bus.memWriteType   = bus.cpuWriteType;
        bus.memWriteEnable = bus.cpuReq && bus.cpuWriteEnable
                             && !reset;
        if (dma_grant) begin
            bus.memAddress     = bus.dmaAddress & ~32'h3;
            bus.memReadType    = ORIGIN_WORD;
            bus.memWriteEnable = bus.dmaWriteEnable;
            bus.memWriteValue  = bus.dmaWriteValue;
            bus.memWriteType   = bus.dmaWriteEnable ? WRITE_WORD
                                                    : WRITE_NONE;
        end else if (!bus.cpuReq) begin
            bus.memWriteEnable = 1'b0;
            bus.memWriteType   = WRITE_NONE;
        end
    end

    // DMA read return: capture the word and pulse valid next cycle.
    always_comb begin
        dma_read_valid_d = dma_grant && !bus.dmaWriteEnable;
        dma_read_data_d  = dma_read_data_q;
        if (dma_read_valid_d) begin
            dma_read_data_d = bus.memReadResult;
        end
        bus.dmaReadValid = dma_read_valid_q;
        bus.dmaReadData  = dma_read_data_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_count_q     <= '0;
            dma_read_valid_q <= 1'b0;
            dma_read_data_q  <= '0;
        end else begin
            wait_count_q     <= wait_count_d;
            dma_read_valid_q <= dma_read_valid_d;
            dma_read_data_q  <= dma_read_data_d;
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a small word memory model
// and a second instance built with STARVE_LIMIT = 1.
module tb_data_memory_arbiter;
    import data_memory_arbiter_pkg::*;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    data_memory_arbiter_if bus ();
    data_memory_arbiter_if bus1 ();

    data_memory_arbiter #(
        .STARVE_LIMIT (4),
        .WAIT_WIDTH   (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    data_memory_arbiter #(
        .STARVE_LIMIT (1),
        .WAIT_WIDTH   (8)
    ) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [31:0] mem [64];
    logic [5:0]  widx;
    logic [1:0]  boff;

    assign widx = bus.memAddress[7:2];
    assign boff = bus.memAddress[1:0];
    assign bus.memReadResult  = mem[widx];
    assign bus1.memReadResult = 32'h0;

    // Memory model: combinational read, write at the clock edge.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[8]  <= 32'h12345678;
            mem[16] <= 32'hFFFFFFFF;
        end else if (bus.memWriteEnable) begin
            case (bus.memWriteType)
                WRITE_WORD: mem[widx] <= bus.memWriteValue;
                WRITE_HALF:
                    mem[widx][16*boff[1] +: 16] <=
                        bus.memWriteValue[15:0];
                WRITE_BYTE:
                    mem[widx][8*boff +: 8] <=
                        bus.memWriteValue[7:0];
                default: ;
            endcase
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cpu_load(input logic [31:0] a);
        bus.cpuReq         = 1'b1;
        bus.cpuAddress     = a;
        bus.cpuReadType    = ORIGIN_WORD;
        bus.cpuWriteEnable = 1'b0;
        bus.cpuWriteValue  = 32'h0;
        bus.cpuWriteType   = WRITE_NONE;
    endtask

    task automatic dma_set(input logic r, input logic we,
                           input logic [31:0] a,
                           input logic [31:0] v);
        bus.dmaReq         = r;
        bus.dmaWriteEnable = we;
        bus.dmaAddress     = a;
        bus.dmaWriteValue  = v;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.cpuReq         = 1'b1;
        bus.cpuAddress     = 32'h10;
        bus.cpuReadType    = ORIGIN_WORD;
        bus.cpuWriteEnable = 1'b1;
        bus.cpuWriteValue  = 32'h55;
        bus.cpuWriteType   = WRITE_WORD;
        dma_set(1'b1, 1'b1, 32'h40, 32'h1);
        bus1.cpuReq         = 1'b0;
        bus1.cpuAddress     = 32'h0;
        bus1.cpuReadType    = ORIGIN_WORD;
        bus1.cpuWriteEnable = 1'b0;
        bus1.cpuWriteValue  = 32'h0;
        bus1.cpuWriteType   = WRITE_NONE;
        bus1.dmaReq         = 1'b0;
        bus1.dmaAddress     = 32'h0;
        bus1.dmaWriteEnable = 1'b0;
        bus1.dmaWriteValue  = 32'h0;

        // 1: reset dominates everything
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #2;
            check("rst_mwe", 32'(bus.memWriteEnable), 32'd0);
            check("rst_gnt", 32'(bus.dmaGrant), 32'd0);
            check("rst_stall", 32'(bus.cpuStall), 32'd0);
            check("rst_rv", 32'(bus.dmaReadValid), 32'd0);
            check("rst_rd", bus.dmaReadData, 32'h0);
        end

        // 2: DMA word write, address aligned down
        @(negedge clock);
        reset = 1'b0;
        bus.cpuReq = 1'b0;
        bus.cpuWriteEnable = 1'b0;
        dma_set(1'b1, 1'b1, 32'h13, 32'hDEADBEEF);
        #2;
        check("w_addr", bus.memAddress, 32'h10);
        check("w_type", 32'(bus.memWriteType), 32'(WRITE_WORD));
        check("w_gnt", 32'(bus.dmaGrant), 32'd1);
        check("w_mwe", 32'(bus.memWriteEnable), 32'd1);
        check("w_val", bus.memWriteValue, 32'hDEADBEEF);
        @(negedge clock);
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        cpu_load(32'h10);
        #2;
        check("ld_data", bus.cpuReadResult, 32'hDEADBEEF);
        check("ld_stall", 32'(bus.cpuStall), 32'd0);
        check("ld_rv", 32'(bus.dmaReadValid), 32'd0);

        // 3: single DMA read, one-cycle valid pulse
        @(negedge clock);
        bus.cpuReq = 1'b0;
        dma_set(1'b1, 1'b0, 32'h20, 32'h0);
        #2;
        check("r_gnt", 32'(bus.dmaGrant), 32'd1);
        check("r_addr", bus.memAddress, 32'h20);
        check("r_mwe", 32'(bus.memWriteEnable), 32'd0);
        check("r_rtype", 32'(bus.memReadType), 32'(ORIGIN_WORD));
        @(negedge clock);
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        check("r_rv1", 32'(bus.dmaReadValid), 32'd1);
        check("r_rd1", bus.dmaReadData, 32'h12345678);
        @(negedge clock); #2;
        check("r_rv2", 32'(bus.dmaReadValid), 32'd0);
        check("r_hold", bus.dmaReadData, 32'h12345678);

        // back-to-back DMA reads with the CPU idle
        @(negedge clock);
        dma_set(1'b1, 1'b0, 32'h10, 32'h0);
        #2;
        check("bb_gnt0", 32'(bus.dmaGrant), 32'd1);
        check("bb_rv0", 32'(bus.dmaReadValid), 32'd0);
        @(negedge clock);
        bus.dmaAddress = 32'h20;
        #2;
        check("bb_gnt1", 32'(bus.dmaGrant), 32'd1);
        check("bb_rv1", 32'(bus.dmaReadValid), 32'd1);
        check("bb_rd1", bus.dmaReadData, 32'hDEADBEEF);
        @(negedge clock);
        bus.dmaAddress = 32'h10;
        #2;
        check("bb_gnt2", 32'(bus.dmaGrant), 32'd1);
        check("bb_rv2", 32'(bus.dmaReadValid), 32'd1);
        check("bb_rd2", bus.dmaReadData, 32'h12345678);
        @(negedge clock);
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        check("bb_rv3", 32'(bus.dmaReadValid), 32'd1);
        check("bb_rd3", bus.dmaReadData, 32'hDEADBEEF);
        @(negedge clock); #2;
        check("bb_rv4", 32'(bus.dmaReadValid), 32'd0);

        // 4: continuous contention, forced grant on cycles 4 and 9
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            cpu_load(32'h10);
            dma_set(1'b1, 1'b0, 32'h20, 32'h0);
            #2;
            check($sformatf("c_gnt%0d", i), 32'(bus.dmaGrant),
                  32'((i == 4) || (i == 9)));
            check($sformatf("c_stl%0d", i), 32'(bus.cpuStall),
                  32'((i == 4) || (i == 9)));
            check($sformatf("c_adr%0d", i), bus.memAddress,
                  ((i == 4) || (i == 9)) ? 32'h20 : 32'h10);
        end
        @(negedge clock);
        bus.cpuReq = 1'b0;
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        check("c_rv", 32'(bus.dmaReadValid), 32'd1);
        check("c_rd", bus.dmaReadData, 32'h12345678);

        // 5: forced DMA write beats a stalled CPU byte store
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            cpu_load(32'h10);
            dma_set(1'b1, 1'b1, 32'h40, 32'h0);
            #2;
            check($sformatf("s_gnt%0d", i), 32'(bus.dmaGrant), 32'd0);
        end
        @(negedge clock);
        bus.cpuAddress     = 32'h41;
        bus.cpuWriteEnable = 1'b1;
        bus.cpuWriteValue  = 32'hAA;
        bus.cpuWriteType   = WRITE_BYTE;
        #2;
        check("s_gnt4", 32'(bus.dmaGrant), 32'd1);
        check("s_stall", 32'(bus.cpuStall), 32'd1);
        check("s_addr", bus.memAddress, 32'h40);
        check("s_val", bus.memWriteValue, 32'h0);
        check("s_type", 32'(bus.memWriteType), 32'(WRITE_WORD));
        @(negedge clock);
        bus.dmaReq = 1'b0;
        #2;
        check("s_mem0", mem[16], 32'h0);
        check("s_stall2", 32'(bus.cpuStall), 32'd0);
        check("s_type2", 32'(bus.memWriteType), 32'(WRITE_BYTE));
        check("s_addr2", bus.memAddress, 32'h41);
        check("s_mwe2", 32'(bus.memWriteEnable), 32'd1);
        @(negedge clock);
        bus.cpuReq = 1'b0;
        #2;
        check("s_mem1", mem[16], 32'h0000AA00);
        check("s_mwe3", 32'(bus.memWriteEnable), 32'd0);
        check("s_type3", 32'(bus.memWriteType), 32'(WRITE_NONE));

        // 6: dropping dmaReq clears the accumulated wait
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            cpu_load(32'h10);
            dma_set(1'b1, 1'b0, 32'h20, 32'h0);
            #2;
            check($sformatf("d_gnt%0d", i), 32'(bus.dmaGrant), 32'd0);
        end
        @(negedge clock);
        bus.dmaReq = 1'b0;
        #2;
        check("d_gnt_off", 32'(bus.dmaGrant), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.dmaReq = 1'b1;
            #2;
            check($sformatf("d_rg%0d", i), 32'(bus.dmaGrant),
                  32'(i == 4));
        end

        // 7: STARVE_LIMIT = 1 alternates under contention
        @(negedge clock);
        bus.cpuReq = 1'b0;
        bus.dmaReq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            bus1.cpuReq = 1'b1;
            bus1.dmaReq = 1'b1;
            #2;
            check($sformatf("a_gnt%0d", i), 32'(bus1.dmaGrant),
                  32'(i % 2 == 1));
            check($sformatf("a_stl%0d", i), 32'(bus1.cpuStall),
                  32'(i % 2 == 1));
        end

        // 8: reset mid-wait discards the accumulated wait
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            cpu_load(32'h10);
            dma_set(1'b1, 1'b0, 32'h20, 32'h0);
            #2;
            check($sformatf("m_gnt%0d", i), 32'(bus.dmaGrant), 32'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        #2;
        check("m_rgnt", 32'(bus.dmaGrant), 32'd0);
        check("m_rstl", 32'(bus.cpuStall), 32'd0);
        check("m_rmwe", 32'(bus.memWriteEnable), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            reset = 1'b0;
            #2;
            check($sformatf("m_rg%0d", i), 32'(bus.dmaGrant),
                  32'(i == 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM stage (CPU port) and a word-wide loader/DMA port.
- The CPU has fixed priority. A starvation counter forces a one-cycle DMA grant, and stalls the pipeline, once DMA has waited STARVE_LIMIT consecutive cycles.
- Sits between the MEM stage and the data memory and drives all memory request inputs. Memory reads are combinational; memory writes commit at the clock edge.

Parameters:
STARVE_LIMIT, 4, consecutive denied DMA-request cycles before a forced DMA grant; legal range 1..255.
WAIT_WIDTH, 8, width of the wait counter; must hold STARVE_LIMIT.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cpuReq  in  1  MEM stage needs memory this cycle (load or store)
cpuAddress  in  32  CPU byte address
cpuReadType  in  read_type_t  CPU load type
cpuWriteEnable  in  1  CPU store
cpuWriteValue  in  32  CPU store data
cpuWriteType  in  write_type_t  CPU store width
cpuStall  out  1  MEM stage must hold its request; no CPU access this cycle
cpuReadResult  out  32  load data; combinational, valid when cpuReq && !cpuStall
dmaReq  in  1  DMA request; held until dmaGrant
dmaAddress  in  32  DMA byte address; bits [1:0] forced to 0
dmaWriteEnable  in  1  DMA word write
dmaWriteValue  in  32  DMA write data
dmaGrant  out  1  DMA access performed this cycle
dmaReadValid  out  1  one-cycle pulse, the cycle after a DMA read grant
dmaReadData  out  32  registered DMA read word
memAddress  out  32  to data memory
memReadType  out  read_type_t  to data memory
memWriteEnable  out  1  to data memory
memWriteValue  out  32  to data memory
memWriteType  out  write_type_t  to data memory
memReadResult  in  32  from data memory

Behaviour:
Arbitration and counter:
- Internal waitCount, WAIT_WIDTH bits, saturating at STARVE_LIMIT.
- forceDma = dmaReq && waitCount == STARVE_LIMIT.
- dmaGrant = !reset && dmaReq && (!cpuReq || forceDma). Combinational, same cycle as the request.
- cpuStall = !reset && cpuReq && dmaGrant.
- waitCount next value:
  - 0 on reset, on dmaGrant, or when dmaReq is low;
  - otherwise min(waitCount+1, STARVE_LIMIT).

Memory mux when dmaGrant:
- memAddress = {dmaAddress[31:2], 2'b00}
- memReadType = ORIGIN_WORD
- memWriteEnable = dmaWriteEnable
- memWriteType = dmaWriteEnable ? WRITE_WORD : WRITE_NONE
- memWriteValue = dmaWriteValue

Memory mux otherwise:
- CPU fields pass through.
- memWriteEnable = cpuReq && cpuWriteEnable && !reset.
- When cpuReq is low, memWriteEnable = 0 and memWriteType = WRITE_NONE.

Read return:
- cpuReadResult = memReadResult at all times; meaningful only on an unstalled CPU cycle.
- On a DMA grant with dmaWriteEnable = 0: dmaReadData <= memReadResult and dmaReadValid <= 1 at the next edge.
- dmaReadValid is 0 in all other cycles. dmaReadData holds its value until the next DMA read.

Reset:
- waitCount, dmaReadValid and dmaReadData = 0.
- While reset is high: dmaGrant, cpuStall and memWriteEnable = 0.
- Reset mid-wait discards the accumulated wait. A pending dmaReadValid pulse is suppressed if reset is high at that edge.

Boundary conditions:
- A forced grant lasts exactly one cycle; waitCount returns to 0, so the CPU wins the next STARVE_LIMIT contended cycles.
- dmaReq dropping before grant clears waitCount; no grant is issued.
- DMA write plus stalled CPU store in the same cycle: only the DMA write reaches memory. The CPU store is re-presented next cycle by the held pipeline.
- STARVE_LIMIT = 1: under continuous contention, CPU and DMA alternate cycles.
- Back-to-back DMA reads with cpuReq low: a grant every cycle and dmaReadValid high every cycle after the first.

Test Plan:
1. Reset high 2 cycles with cpuReq=dmaReq=1, dmaWriteEnable=1 -> memWriteEnable=0, dmaGrant=0, cpuStall=0, dmaReadValid=0 throughout.
2. cpuReq=0; DMA write 0xDEADBEEF to address 0x00000013 -> same cycle memAddress=0x00000010, memWriteType=WRITE_WORD, dmaGrant=1. A following CPU ORIGIN_WORD load from 0x10 returns 0xDEADBEEF with no stall.
3. DMA read of 0x20 (holding 0x12345678) with cpuReq=0 -> dmaGrant=1 that cycle; next cycle dmaReadValid=1 and dmaReadData=0x12345678; pulse lasts one cycle.
4. STARVE_LIMIT=4, cpuReq and dmaReq held high -> dmaGrant=0 for cycles 0..3, then dmaGrant=1 and cpuStall=1 on cycle 4, then CPU unstalled for cycles 5..8, then forced again on cycle 9.
5. Contended cycle: CPU WRITE_BYTE 0xAA to 0x41 while DMA is forced to write 0x0 to 0x40 -> memory word 0x40 = 0x00000000 after the DMA cycle. CPU store re-presented next cycle yields word 0x0000AA00.
6. dmaReq high 3 cycles under contention, dropped for 1 cycle, re-raised -> no grant until 4 further contended cycles elapse, proving waitCount cleared.
